// File: rtl/mul_pkg.sv
// mul_pkg: op codes, FSM state encoding and counter sizing for mul_unit_iter.
package mul_pkg;
    localparam logic [2:0] MUL_OP   = 3'b101;
    localparam logic [2:0] UMULL_OP = 3'b110;
    localparam logic [2:0] SMULL_OP = 3'b111;
    localparam int         MUL_WIDTH = 32;
    localparam int         ITER_W    = $clog2(MUL_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    function automatic int iter_w(input int w);
        return $clog2(w) + 1;
    endfunction
endpackage

// File: rtl/mul_neg_cond.sv
// mul_neg_cond: conditional two's-complement negate.
module mul_neg_cond #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);
    assign y = neg ? -x : x;
endmodule

// File: rtl/mul_unit_iter.sv
// mul_unit_iter: radix-2 shift-add multiplier for MUL/UMULL/SMULL.
// MUL_UNIT_EARLY_TERM_EN stops iterating once the remaining multiplier bits are zero.
module mul_unit_iter
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             flag_n,
    output logic             flag_z
);
    localparam int IW = iter_w(WIDTH);

    state_t             state, state_nx;
    logic [2:0]         op_q;
    logic               neg;
    logic [WIDTH-1:0]   mcand, mplr, abs_a, abs_b, hi_v;
    logic [2*WIDTH-1:0] acc, aligned, prod;
    logic [IW-1:0]      cnt;
    logic [WIDTH:0]     sum;
    logic               accept, last, is_mul, n_v, z_v;

    assign accept = start && (op == MUL_OP || op == UMULL_OP || op == SMULL_OP)
                    && (state == IDLE || state == DONE);
    assign busy   = state == CALC || state == SIGN;
    assign done   = state == DONE;

    mul_neg_cond #(.W(WIDTH)) u_abs_a (.neg(op == SMULL_OP && a[WIDTH-1]), .x(a), .y(abs_a));
    mul_neg_cond #(.W(WIDTH)) u_abs_b (.neg(op == SMULL_OP && b[WIDTH-1]), .x(b), .y(abs_b));

    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplr[0] ? mcand : '0)};

`ifdef MUL_UNIT_EARLY_TERM_EN
    assign last    = cnt == IW'(WIDTH - 1) || mplr[WIDTH-1:1] == '0;
    // acc holds product << (WIDTH - iterations) when iteration stops early
    assign aligned = acc >> (WIDTH - int'(cnt));
`else
    assign last    = cnt == IW'(WIDTH - 1);
    assign aligned = acc;
`endif

    mul_neg_cond #(.W(2*WIDTH)) u_fix (.neg(neg), .x(aligned), .y(prod));

    assign is_mul = op_q == MUL_OP;
    assign hi_v   = is_mul ? '0 : prod[2*WIDTH-1:WIDTH];
    assign n_v    = is_mul ? prod[WIDTH-1] : hi_v[WIDTH-1];
    assign z_v    = is_mul ? prod[WIDTH-1:0] == '0 : prod == '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? CALC : IDLE;
            CALC:    state_nx = last ? SIGN : CALC;
            SIGN:    state_nx = DONE;
            DONE:    state_nx = accept ? CALC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= '0;
            neg    <= 1'b0;
            mcand  <= '0;
            mplr   <= '0;
            acc    <= '0;
            cnt    <= '0;
            res_lo <= '0;
            res_hi <= '0;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q  <= op;
                neg   <= op == SMULL_OP && (a[WIDTH-1] ^ b[WIDTH-1]);
                mcand <= abs_a;
                mplr  <= abs_b;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == CALC) begin
                acc  <= {sum, acc[WIDTH-1:1]};
                mplr <= mplr >> 1;
                cnt  <= cnt + 1'b1;
            end else if (state == SIGN) begin
                res_lo <= prod[WIDTH-1:0];
                res_hi <= hi_v;
                flag_n <= n_v;
                flag_z <= z_v;
            end
        end
    end
endmodule
